parking_slot_manager: RTL and testbench
=======================================

# parking_slot_manager

Sequential occupancy tracker and gate controller for the 8-slot car park. Registers which slots are free, admits cars at the entry gate, releases slots at the exit gate, and drives both gate barriers for a fixed open time. Its `parking_capacity` output is the free-slot bitmap that the downstream slot-assignment logic consumes directly. It also reports the slot it assigned to each admitted car.

## Interface

Parameters:
- `GATE_CYCLES`, default 4: number of cycles a barrier stays open per serviced car. Legal range is 1..255.

Ports:
- `clk`  in  1  single system clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `entry`  in  1  level; car present at the entry sensor.
- `exit`  in  1  level; car present at the exit sensor.
- `exit_slot`  in  3  slot number of the leaving car; sampled with `exit`.
- `parking_capacity`  out  8  free bitmap; bit i = 1 means slot i is free.
- `free_count`  out  4  number of free slots, 0..8.
- `full`  out  1  high when `free_count` == 0.
- `entry_ack`  out  1  one-cycle pulse when a car is admitted.
- `entry_slot`  out  3  slot assigned to the last admitted car; holds its value until the next admission.
- `entry_reject`  out  1  one-cycle pulse when an entry is refused because the park is full.
- `exit_ack`  out  1  one-cycle pulse when a slot is released.
- `exit_err`  out  1  one-cycle pulse when `exit_slot` is already free.
- `gate_in_open`  out  1  entry barrier open.
- `gate_out_open`  out  1  exit barrier open.

## Operation

- All outputs are registered.
- Reset values:
  - `parking_capacity`=8'hFF, `free_count`=8, `full`=0, `entry_slot`=0.
  - All pulse outputs and both gate outputs are 0.
  - State=IDLE, timer=0, `entry_armed`=1, `exit_armed`=1.
- Arming:
  - A request is serviced only while its armed flag is 1.
  - The flag clears when the request is serviced, rejected or errored.
  - The flag sets on any cycle in which its input is sampled low.
  - Net effect: one service per assertion of `entry`/`exit`, however long the level is held.
- State machine states: IDLE, IN_OPEN, OUT_OPEN.
- IDLE with `exit` && `exit_armed`. Exit has priority over entry.
  - If slot `exit_slot` is occupied: set its bit, increment `free_count`, pulse `exit_ack`, set `gate_out_open`, load timer with `GATE_CYCLES`, go to OUT_OPEN.
  - Otherwise: pulse `exit_err`, no state change, stay in IDLE.
- IDLE otherwise, with `entry` && `entry_armed`:
  - If not full: take the lowest-index free slot, clear its bit, decrement `free_count`, write `entry_slot`, pulse `entry_ack`, set `gate_in_open`, load timer, go to IN_OPEN.
  - If full: pulse `entry_reject`, stay in IDLE, gate stays closed.
- IN_OPEN / OUT_OPEN:
  - Timer decrements each cycle.
  - When the timer would reach 0, clear the gate output and return to IDLE.
  - Requests arriving in these states are not serviced. They are held pending while still asserted and armed, and are evaluated in IDLE.
- `free_count` always equals the popcount of `parking_capacity`. `full` is derived from the next-state count, so it is never one cycle stale.
- `free_count` never goes below 0 or above 8; both limits are guaranteed by the occupied/free checks above.

## Timing

- A request sampled in IDLE at edge N produces, at edge N:
  - the ack/reject/err pulse high for exactly the one cycle following that edge;
  - the `parking_capacity` / `free_count` / `full` update;
  - the gate assertion.
- Gate output is high for exactly `GATE_CYCLES` consecutive cycles, starting in the same cycle as the ack.
- Earliest next service is at the first edge after the gate closes, i.e. request-to-request spacing is at least `GATE_CYCLES`+1 cycles.
- A reject or error costs one cycle and leaves the FSM in IDLE.
- Simultaneous `entry` and `exit` in IDLE: exit is serviced first. The entry is serviced after OUT_OPEN completes if `entry` is still high; it can then receive the slot just freed.
- Reset asserted mid-operation (any state) returns every output to its reset value at the next edge. Reset overrides any request sampled on that edge.

## Test plan

- **Fill the park:** reset, then 8 `entry` pulses each 1 cycle wide, spaced `GATE_CYCLES`+2 apart. Required: `entry_slot` = 0,1,…,7 in order; `parking_capacity` ends at 8'h00, `free_count`=0, `full`=1; each `gate_in_open` is high for exactly 4 cycles.
- **Entry when full:** from the full state, pulse `entry`. Required: `entry_reject` high for 1 cycle, no `entry_ack`, `gate_in_open` stays 0, `parking_capacity` stays 8'h00.
- **Exit then re-entry:** from full, `exit` with `exit_slot`=3. Required: `exit_ack`, `parking_capacity`=8'h08, `full`=0, `gate_out_open` high for 4 cycles. A following `entry` gives `entry_slot`=3 and `parking_capacity`=8'h00.
- **Exit of a free slot:** from reset, `exit` with `exit_slot`=5. Required: `exit_err` high for 1 cycle, no gate activity, `parking_capacity` stays 8'hFF.
- **Simultaneous entry and exit:** from full, assert `entry` and `exit` (`exit_slot`=6) in the same cycle and hold both. Required: `exit_ack` first; after OUT_OPEN, `entry_ack` with `entry_slot`=6; exactly one service each.
- **Held entry and reset mid-gate:** hold `entry` high for 20 cycles. Required: exactly one `entry_ack`. Then assert `rst` during IN_OPEN. Required: next cycle `gate_in_open`=0, `parking_capacity`=8'hFF, `free_count`=8.

Source files
------------

// File: rtl/parking_slot_manager.sv
// Eight-slot car park occupancy tracker with entry/exit gate control.
// Admits cars into the lowest free slot and times each barrier opening.
module parking_slot_manager #(
  parameter int unsigned GATE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       entry,
  input  logic       exit,
  input  logic [2:0] exit_slot,
  output logic [7:0] parking_capacity,
  output logic [3:0] free_count,
  output logic       full,
  output logic       entry_ack,
  output logic [2:0] entry_slot,
  output logic       entry_reject,
  output logic       exit_ack,
  output logic       exit_err,
  output logic       gate_in_open,
  output logic       gate_out_open
);

  typedef enum logic [1:0] {
    IDLE,
    IN_OPEN,
    OUT_OPEN
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] timer_q, timer_d;
  logic [7:0] cap_q, cap_d;
  logic [3:0] cnt_q, cnt_d;
  logic       full_q, full_d;
  logic       eack_q, eack_d;
  logic [2:0] eslot_q, eslot_d;
  logic       erej_q, erej_d;
  logic       xack_q, xack_d;
  logic       xerr_q, xerr_d;
  logic       gin_q, gin_d;
  logic       gout_q, gout_d;
  logic       earm_q, earm_d;
  logic       xarm_q, xarm_d;
  logic [2:0] low_slot;

  // Descending scan so the lowest free index wins.
  always_comb begin
    low_slot = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (cap_q[i]) low_slot = 3'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    cap_d   = cap_q;
    cnt_d   = cnt_q;
    eslot_d = eslot_q;
    gin_d   = gin_q;
    gout_d  = gout_q;
    earm_d  = earm_q;
    xarm_d  = xarm_q;
    eack_d  = 1'b0;
    erej_d  = 1'b0;
    xack_d  = 1'b0;
    xerr_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (exit && xarm_q) begin
          xarm_d = 1'b0;
          if (!cap_q[exit_slot]) begin
            cap_d[exit_slot] = 1'b1;
            cnt_d   = cnt_q + 4'd1;
            xack_d  = 1'b1;
            gout_d  = 1'b1;
            timer_d = 8'(GATE_CYCLES);
            state_d = OUT_OPEN;
          end else begin
            xerr_d = 1'b1;
          end
        end else if (entry && earm_q) begin
          earm_d = 1'b0;
          if (cnt_q != 4'd0) begin
            cap_d[low_slot] = 1'b0;
            cnt_d   = cnt_q - 4'd1;
            eslot_d = low_slot;
            eack_d  = 1'b1;
            gin_d   = 1'b1;
            timer_d = 8'(GATE_CYCLES);
            state_d = IN_OPEN;
          end else begin
            erej_d = 1'b1;
          end
        end
      end
      IN_OPEN, OUT_OPEN: begin
        timer_d = timer_q - 8'd1;
        if (timer_q == 8'd1) begin
          gin_d   = 1'b0;
          gout_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!entry) earm_d = 1'b1;
    if (!exit)  xarm_d = 1'b1;
    full_d = (cnt_d == 4'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      timer_q <= 8'd0;
      cap_q   <= 8'hFF;
      cnt_q   <= 4'd8;
      full_q  <= 1'b0;
      eack_q  <= 1'b0;
      eslot_q <= 3'd0;
      erej_q  <= 1'b0;
      xack_q  <= 1'b0;
      xerr_q  <= 1'b0;
      gin_q   <= 1'b0;
      gout_q  <= 1'b0;
      earm_q  <= 1'b1;
      xarm_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      cap_q   <= cap_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      eack_q  <= eack_d;
      eslot_q <= eslot_d;
      erej_q  <= erej_d;
      xack_q  <= xack_d;
      xerr_q  <= xerr_d;
      gin_q   <= gin_d;
      gout_q  <= gout_d;
      earm_q  <= earm_d;
      xarm_q  <= xarm_d;
    end
  end

  assign parking_capacity = cap_q;
  assign free_count       = cnt_q;
  assign full             = full_q;
  assign entry_ack        = eack_q;
  assign entry_slot       = eslot_q;
  assign entry_reject     = erej_q;
  assign exit_ack         = xack_q;
  assign exit_err         = xerr_q;
  assign gate_in_open     = gin_q;
  assign gate_out_open    = gout_q;

endmodule

// File: tb/tb_parking_slot_manager.sv
// Self-checking bench for parking_slot_manager.
// Directed scenarios plus random traffic against a behavioural car-park model.
module tb_parking_slot_manager;

  localparam int G = 4;

  logic       clk = 1'b0;
  logic       r_i = 1'b0;
  logic       e_i = 1'b0;
  logic       x_i = 1'b0;
  logic [2:0] xs_i = 3'd0;
  logic [7:0] cap;
  logic [3:0] fc;
  logic       full, eack, erej, xack, xerr, gin, gout;
  logic [2:0] eslot;

  int errs = 0;
  int checks = 0;

  parking_slot_manager #(.GATE_CYCLES(G)) dut (
    .clk(clk),
    .rst(r_i),
    .entry(e_i),
    .exit(x_i),
    .exit_slot(xs_i),
    .parking_capacity(cap),
    .free_count(fc),
    .full(full),
    .entry_ack(eack),
    .entry_slot(eslot),
    .entry_reject(erej),
    .exit_ack(xack),
    .exit_err(xerr),
    .gate_in_open(gin),
    .gate_out_open(gout)
  );

  always #5 clk = ~clk;

  wire [21:0] dut_v = {cap, fc, full, eack, eslot, erej,
                       xack, xerr, gin, gout};

  // Behavioural model: a set of free slots plus a countdown of
  // remaining open cycles for whichever barrier is up.
  bit       m_free [8];
  int       m_left;
  bit       m_gin, m_gout, m_ea, m_xa;
  bit       m_eack, m_erej, m_xack, m_xerr;
  int       m_slot;

  function automatic int m_count();
    int n = 0;
    foreach (m_free[i]) n += m_free[i];
    return n;
  endfunction

  function automatic logic [21:0] exp_v();
    logic [7:0] c;
    int n;
    foreach (m_free[i]) c[i] = m_free[i];
    n = m_count();
    return {c, 4'(n), (n == 0), m_eack, 3'(m_slot), m_erej,
            m_xack, m_xerr, m_gin, m_gout};
  endfunction

  task automatic m_reset();
    foreach (m_free[i]) m_free[i] = 1'b1;
    m_left = 0; m_gin = 0; m_gout = 0; m_ea = 1; m_xa = 1;
    m_slot = 0;
  endtask

  task automatic m_edge();
    m_eack = 0; m_erej = 0; m_xack = 0; m_xerr = 0;
    if (r_i) begin
      m_reset();
      return;
    end
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin m_gin = 0; m_gout = 0; end
    end else if (x_i && m_xa) begin
      m_xa = 0;
      if (!m_free[xs_i]) begin
        m_free[xs_i] = 1; m_xack = 1; m_gout = 1; m_left = G;
      end else m_xerr = 1;
    end else if (e_i && m_ea) begin
      m_ea = 0;
      if (m_count() > 0) begin
        for (int i = 0; i < 8; i++)
          if (m_free[i]) begin m_slot = i; break; end
        m_free[m_slot] = 0; m_eack = 1; m_gin = 1; m_left = G;
      end else m_erej = 1;
    end
    if (!e_i) m_ea = 1;
    if (!x_i) m_xa = 1;
  endtask

  task automatic step();
    @(posedge clk);
    m_edge();
    #1;
  endtask

  task automatic test_reset();
    r_i = 1; step(); r_i = 0;
    checks++;
    if (dut_v !== {8'hFF, 4'd8, 1'b0, 1'b0, 3'd0, 5'b0}) begin
      errs++; $display("FAIL reset got=%h exp=%h", dut_v,
        {8'hFF, 4'd8, 1'b0, 1'b0, 3'd0, 5'b0});
    end
  endtask

  task automatic test_fill();
    int g;
    for (int k = 0; k < 8; k++) begin
      e_i = 1; step(); e_i = 0;
      checks++;
      if (eack !== 1'b1 || eslot !== 3'(k)) begin
        errs++; $display("FAIL fill_slot%0d got=%b/%0d exp=1/%0d",
          k, eack, eslot, k);
      end
      g = gin;
      for (int c = 0; c < 5; c++) begin
        step();
        g += gin;
        checks++;
        if (dut_v !== exp_v()) begin
          errs++; $display("FAIL fill_model got=%h exp=%h",
            dut_v, exp_v());
        end
      end
      checks++;
      if (g != G) begin
        errs++; $display("FAIL fill_gate got=%0d exp=%0d", g, G);
      end
    end
    checks++;
    if ({cap, fc, full} !== {8'h00, 4'd0, 1'b1}) begin
      errs++; $display("FAIL fill_end got=%h/%0d/%b exp=00/0/1",
        cap, fc, full);
    end
  endtask

  task automatic test_full_reject();
    int rej = 0, ack = 0, g = 0;
    e_i = 1; step(); e_i = 0;
    rej += erej; ack += eack; g += gin;
    for (int c = 0; c < 4; c++) begin
      step();
      rej += erej; ack += eack; g += gin;
    end
    checks++;
    if (rej != 1 || ack != 0 || g != 0 || cap !== 8'h00) begin
      errs++; $display("FAIL full_reject got=%0d/%0d/%0d/%h exp=1/0/0/00",
        rej, ack, g, cap);
    end
  endtask

  task automatic test_exit_reentry();
    int g;
    x_i = 1; xs_i = 3'd3; step(); x_i = 0;
    checks++;
    if ({xack, cap, full} !== {1'b1, 8'h08, 1'b0}) begin
      errs++; $display("FAIL exit3 got=%b/%h/%b exp=1/08/0",
        xack, cap, full);
    end
    g = gout;
    for (int c = 0; c < 5; c++) begin step(); g += gout; end
    checks++;
    if (g != G) begin
      errs++; $display("FAIL exit_gate got=%0d exp=%0d", g, G);
    end
    e_i = 1; step(); e_i = 0;
    checks++;
    if ({eack, eslot, cap} !== {1'b1, 3'd3, 8'h00}) begin
      errs++; $display("FAIL reentry got=%b/%0d/%h exp=1/3/00",
        eack, eslot, cap);
    end
    for (int c = 0; c < 5; c++) step();
  endtask

  task automatic test_simultaneous();
    int xa = 0, ea = 0, xt = -1, et = -1;
    logic [2:0] s = 3'd0;
    e_i = 1; x_i = 1; xs_i = 3'd6;
    for (int c = 0; c < 16; c++) begin
      step();
      if (c == 14) begin e_i = 0; x_i = 0; end
      if (xack) begin xa++; xt = c; end
      if (eack) begin ea++; et = c; s = eslot; end
      checks++;
      if (dut_v !== exp_v()) begin
        errs++; $display("FAIL simul_model got=%h exp=%h",
          dut_v, exp_v());
      end
    end
    checks++;
    if (xa != 1 || ea != 1 || xt != 0 || et != G + 1 || s !== 3'd6) begin
      errs++; $display("FAIL simul got=%0d/%0d/%0d/%0d/%0d exp=1/1/0/%0d/6",
        xa, ea, xt, et, s, G + 1);
    end
  endtask

  task automatic test_exit_free();
    int g = 0;
    r_i = 1; step(); r_i = 0;
    x_i = 1; xs_i = 3'd5; step(); x_i = 0;
    checks++;
    if ({xerr, xack, cap} !== {1'b1, 1'b0, 8'hFF}) begin
      errs++; $display("FAIL exit_free got=%b/%b/%h exp=1/0/FF",
        xerr, xack, cap);
    end
    g += gout;
    for (int c = 0; c < 4; c++) begin step(); g += gout + xerr; end
    checks++;
    if (g != 0) begin
      errs++; $display("FAIL exit_free_gate got=%0d exp=0", g);
    end
  endtask

  task automatic test_held_reset();
    int ea = 0;
    e_i = 1;
    for (int c = 0; c < 20; c++) begin step(); ea += eack; end
    e_i = 0; step();
    checks++;
    if (ea != 1) begin
      errs++; $display("FAIL held_entry got=%0d exp=1", ea);
    end
    e_i = 1; step(); e_i = 0; step();
    checks++;
    if (gin !== 1'b1) begin
      errs++; $display("FAIL mid_gate got=%b exp=1", gin);
    end
    r_i = 1; e_i = 1; step(); r_i = 0; e_i = 0;
    checks++;
    if ({gin, cap, fc, eack} !== {1'b0, 8'hFF, 4'd8, 1'b0}) begin
      errs++; $display("FAIL rst_mid got=%b/%h/%0d/%b exp=0/FF/8/0",
        gin, cap, fc, eack);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      r_i  = ($urandom_range(0, 79) == 0);
      e_i  = ($urandom_range(0, 2) != 0);
      x_i  = ($urandom_range(0, 2) == 0);
      xs_i = 3'($urandom_range(0, 7));
      step();
      checks++;
      if (dut_v !== exp_v()) begin
        errs++; $display("FAIL random c=%0d got=%h exp=%h",
          c, dut_v, exp_v());
      end
    end
    r_i = 0; e_i = 0; x_i = 0;
  endtask

  initial begin
    m_reset();
    m_eack = 0; m_erej = 0; m_xack = 0; m_xerr = 0;
    #2;
    test_reset();
    test_fill();
    test_full_reject();
    test_exit_reentry();
    test_simultaneous();
    test_exit_free();
    test_held_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
